// File: rtl/shift_add_mult_pkg.sv
// shift_add_mult_pkg: FSM state type and encodings for the shift-add multiplier.
package shift_add_mult_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_SIGN = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    SIGN = ST_SIGN,
    DONE = ST_DONE
  } state_t;
endpackage

// File: rtl/cond_negate.sv
// cond_negate: two's-complement negation of i_d when i_en is high, pass-through otherwise.
module cond_negate #(
  parameter int W = 8
) (
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  assign o_q = i_en ? -i_d : i_d;
endmodule

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential N x N -> 2N shift-add multiplier, signed or unsigned.
// Define SHIFT_ADD_MULT_EARLY_EXIT_EN to leave RUN as soon as the multiplier runs out of set bits.
module shift_add_multiplier
  import shift_add_mult_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [N-1:0]   a_in,
  input  logic [N-1:0]   b_in,
  output logic [2*N-1:0] out,
  output logic           busy,
  output logic           finish
);
  localparam int CNT_W = $clog2(N + 1);
  state_t             r_state;
  state_t             w_state_nxt;
  logic [2*N-1:0]     r_mcand;
  logic [N-1:0]       r_mplier;
  logic [2*N-1:0]     r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sign;
  logic [2*N-1:0]     r_out;
  logic [N-1:0]       w_a_mag;
  logic [N-1:0]       w_b_mag;
  logic [2*N-1:0]     w_res;
  logic [N-1:0]       w_mplier_nxt;
  logic               w_sign_nxt;
  logic               w_last_iter;
  cond_negate #(.W(N)) u_neg_a (
    .i_en (signed_mode & a_in[N-1]),
    .i_d  (a_in),
    .o_q  (w_a_mag)
  );
  cond_negate #(.W(N)) u_neg_b (
    .i_en (signed_mode & b_in[N-1]),
    .i_d  (b_in),
    .o_q  (w_b_mag)
  );
  cond_negate #(.W(2*N)) u_neg_res (
    .i_en (r_sign),
    .i_d  (r_acc),
    .o_q  (w_res)
  );
  // A zero operand forces a positive sign so no negative zero is produced.
  assign w_sign_nxt   = signed_mode & (a_in[N-1] ^ b_in[N-1]) & (|a_in) & (|b_in);
  assign w_mplier_nxt = r_mplier >> 1;
`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
  assign w_last_iter  = (r_cnt == CNT_W'(1)) || (w_mplier_nxt == '0);
`else
  assign w_last_iter  = (r_cnt == CNT_W'(1));
`endif
  assign out = r_out;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end
  always_comb begin
    w_state_nxt = r_state;
    busy        = (r_state != IDLE);
    finish      = (r_state == DONE);
    case (r_state)
      IDLE:    w_state_nxt = start ? RUN : IDLE;
      RUN:     w_state_nxt = w_last_iter ? SIGN : RUN;
      SIGN:    w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_sign   <= 1'b0;
      r_out    <= '0;
    end else if (r_state == IDLE && start) begin
      r_mcand  <= {{N{1'b0}}, w_a_mag};
      r_mplier <= w_b_mag;
      r_acc    <= '0;
      r_cnt    <= CNT_W'(N);
      r_sign   <= w_sign_nxt;
    end else if (r_state == RUN) begin
      r_acc    <= r_mplier[0] ? r_acc + r_mcand : r_acc;
      r_mcand  <= r_mcand << 1;
      r_mplier <= w_mplier_nxt;
      r_cnt    <= r_cnt - CNT_W'(1);
    end else if (r_state == SIGN) begin
      r_out    <= w_res;
    end
  end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: vector table plus scoreboard queue for the N=8 multiplier.
module tb_shift_add_multiplier;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        signed_mode = 1'b0;
  logic [7:0]  a_in = '0;
  logic [7:0]  b_in = '0;
  logic [15:0] out;
  logic        busy;
  logic        finish;
  int          total = 0;
  int          bad = 0;
  logic [15:0] last_out = '0;
  logic [15:0] sb_q[$];
  typedef struct {
    logic       sm;
    logic [7:0] a;
    logic [7:0] b;
    logic [15:0] p;
  } vec_t;
  vec_t tbl[9];

  shift_add_multiplier #(.N(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .a_in        (a_in),
    .b_in        (b_in),
    .out         (out),
    .busy        (busy),
    .finish      (finish)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic sm, input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] sa;
    logic signed [15:0] sb;
    sa = $signed(a);
    sb = $signed(b);
    if (sm) return 16'(sa * sb);
    return 16'({8'h0, a} * {8'h0, b});
  endfunction

  function automatic int exp_lat(input logic sm, input logic [7:0] b);
`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
    logic [7:0] m;
    int r;
    m = (sm && b[7]) ? -b : b;
    r = 1;
    for (int i = 0; i < 8; i++) if (m[i]) r = i + 1;
    return r + 1;
`else
    return 9;
`endif
  endfunction

  // Caller aligns to a negedge; start is sampled on the following posedge.
  task automatic run_op(input logic sm, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input bit poke);
    int lat;
    logic [15:0] want;
    signed_mode = sm;
    a_in = a;
    b_in = b;
    start = 1'b1;
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in = 8'($urandom);
    b_in = 8'($urandom);
    signed_mode = ~sm;
    lat = 0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (finish) begin
        lat = e;
        break;
      end
      check("busy_hold", 32'({busy, out}), 32'({1'b1, last_out}));
      if (poke && e == 2) begin
        start = 1'b1;
        a_in = 8'hFF;
        b_in = 8'hFF;
      end
      if (poke && e == 3) start = 1'b0;
    end
    check("latency", 32'(lat), 32'(exp_lat(sm, b)));
    if (sb_q.size() == 0) check("sb_empty", 32'(0), 32'(1));
    else begin
      want = sb_q.pop_front();
      if (lat != 0) begin
        check("product", 32'(out), 32'(want));
        last_out = want;
        @(posedge clk);
        #1;
        check("pulse_end", 32'({finish, busy}), 32'(0));
      end
    end
  endtask

  initial begin
    logic sm;
    logic [7:0] a;
    logic [7:0] b;
    tbl[0] = '{1'b0, 8'd13,  8'd11,  16'h008F};
    tbl[1] = '{1'b0, 8'd255, 8'd255, 16'hFE01};
    tbl[2] = '{1'b1, 8'hFD,  8'h07,  16'hFFEB};
    tbl[3] = '{1'b1, 8'h80,  8'h80,  16'h4000};
    tbl[4] = '{1'b1, 8'h00,  8'hFB,  16'h0000};
    tbl[5] = '{1'b0, 8'd200, 8'd1,   16'h00C8};
    tbl[6] = '{1'b0, 8'd3,   8'd128, 16'h0180};
    tbl[7] = '{1'b1, 8'hFB,  8'h00,  16'h0000};
    tbl[8] = '{1'b1, 8'h7F,  8'h81,  16'hC0FF};
    #1;
    check("rst_out", 32'(out), 32'(0));
    check("rst_flags", 32'({busy, finish}), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 9; i++) begin
      run_op(tbl[i].sm, tbl[i].a, tbl[i].b, tbl[i].p, 1'b0);
      @(negedge clk);
    end
    for (int i = 0; i < 10; i++) begin
      sm = 1'($urandom);
      a = 8'($urandom);
      b = 8'($urandom);
      run_op(sm, a, b, model(sm, a, b), 1'b0);
      @(negedge clk);
    end
    run_op(1'b0, 8'd13, 8'd11, 16'h008F, 1'b1);
    @(negedge clk);
    signed_mode = 1'b0;
    a_in = 8'd100;
    b_in = 8'd100;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort_out", 32'(out), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_finish", 32'(finish), 32'(0));
    last_out = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("abort_no_finish", 32'({finish, busy}), 32'(0));
    end
    @(negedge clk);
    rst = 1'b1;
    run_op(1'b0, 8'd6, 8'd7, 16'h002A, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
